// File: rtl/rvc_asap_mem_arb.sv
// Two-port (instruction/data) arbiter onto a single-port memory with
// data priority, instruction anti-starvation and one-cycle read response routing.
module rvc_asap_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IGnt,
  output logic              IRdValid,
  output logic [31:0]       IRdData,
  input  logic              DReq,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic              DWrEn,
  input  logic [3:0]        DByteEn,
  input  logic [31:0]       DWrData,
  output logic              DGnt,
  output logic              DRdValid,
  output logic [31:0]       DRdData,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [3:0]        MemByteEn,
  output logic [31:0]       MemWrData,
  input  logic              MemReady,
  input  logic [31:0]       MemRdData
);

  localparam logic [2:0] StarveMax = 3'(MAX_STARVE);

  logic [2:0] starve_q, starve_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_owner_q, resp_owner_d;
  logic       arb_en, i_force, i_gnt, d_gnt;

  // Grants are suppressed during reset so nothing can be launched into it.
  always_comb begin
    arb_en  = Rst & MemReady;
    i_force = IReq & (starve_q == StarveMax);
    i_gnt   = arb_en & IReq & (~DReq | i_force);
    d_gnt   = arb_en & DReq & ~i_gnt;
  end

  assign IGnt   = i_gnt;
  assign DGnt   = d_gnt;
  assign MemReq = i_gnt | d_gnt;

  always_comb begin
    MemAddr   = '0;
    MemWrEn   = 1'b0;
    MemByteEn = '0;
    MemWrData = '0;
    if (i_gnt) begin
      MemAddr   = IAddr;
      MemByteEn = '1;
    end else if (d_gnt) begin
      MemAddr   = DAddr;
      MemWrEn   = DWrEn;
      MemByteEn = DByteEn;
      MemWrData = DWrData;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!IReq || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && starve_q != StarveMax) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_comb begin
    resp_valid_d = i_gnt | (d_gnt & ~DWrEn);
    resp_owner_d = resp_valid_d ? d_gnt : resp_owner_q;
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  assign IRdValid = resp_valid_q & ~resp_owner_q;
  assign DRdValid = resp_valid_q & resp_owner_q;
  assign IRdData  = IRdValid ? MemRdData : '0;
  assign DRdData  = DRdValid ? MemRdData : '0;

endmodule

// File: tb/tb_rvc_asap_mem_arb.sv
// Scoreboard bench: stimulus pushes expected grants/responses tagged with cycle;
// a negedge monitor pops and compares whenever the DUT shows a grant or response.
module tb_rvc_asap_mem_arb;

  logic        Clock = 1'b0;
  logic        Rst;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IGnt, IRdValid;
  logic [31:0] IRdData;
  logic        DReq;
  logic [31:0] DAddr;
  logic        DWrEn;
  logic [3:0]  DByteEn;
  logic [31:0] DWrData;
  logic        DGnt, DRdValid;
  logic [31:0] DRdData;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemWrEn;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWrData;
  logic        MemReady;
  logic [31:0] MemRdData;

  localparam logic [31:0] RD_BASE = 32'hC0DE_0000;

  rvc_asap_mem_arb #(.ADDR_W(32), .MAX_STARVE(4)) dut (
    .Clock(Clock), .Rst(Rst),
    .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IRdValid(IRdValid), .IRdData(IRdData),
    .DReq(DReq), .DAddr(DAddr), .DWrEn(DWrEn), .DByteEn(DByteEn), .DWrData(DWrData),
    .DGnt(DGnt), .DRdValid(DRdValid), .DRdData(DRdData),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemByteEn(MemByteEn),
    .MemWrData(MemWrData), .MemReady(MemReady), .MemRdData(MemRdData)
  );

  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] cycle;
    logic        ignt;
    logic        dgnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } gnt_t;

  typedef struct packed {
    logic [31:0] cycle;
    logic        iv;
    logic        dv;
    logic [31:0] idata;
    logic [31:0] ddata;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, compares against queued expectations.
  always @(negedge Clock) begin
    gnt_t ga, ge;
    rsp_t ra, re;
    if (IGnt || DGnt || MemReq) begin
      ga = '{cycle: cyc, ignt: IGnt, dgnt: DGnt, addr: MemAddr, we: MemWrEn,
             be: MemByteEn, wd: MemWrData};
      if (gq.size() == 0) begin
        check("grant_unexpected", 128'(ga), 128'(0));
      end else begin
        ge = gq.pop_front();
        check("grant", 128'({MemReq, ga}), 128'({1'b1, ge}));
      end
    end else begin
      check("idle_mem_zero", 128'({MemAddr, MemWrEn, MemByteEn, MemWrData}), 128'(0));
    end
    if (IRdValid || DRdValid) begin
      ra = '{cycle: cyc, iv: IRdValid, dv: DRdValid, idata: IRdData, ddata: DRdData};
      if (rq.size() == 0) begin
        check("resp_unexpected", 128'(ra), 128'(0));
      end else begin
        re = rq.pop_front();
        check("resp", 128'(ra), 128'(re));
      end
    end
  end

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic [31:0] da, input logic dw, input logic [3:0] be,
                      input logic [31:0] wd, input logic mr, input logic ei,
                      input logic ed, input logic no_resp);
    gnt_t g;
    rsp_t r;
    logic [31:0] d;
    IReq = ir; IAddr = ia; DReq = dr; DAddr = da; DWrEn = dw;
    DByteEn = be; DWrData = wd; MemReady = mr;
    MemRdData = RD_BASE + cyc;
    if (ei) begin
      g = '{cycle: cyc, ignt: 1'b1, dgnt: 1'b0, addr: ia, we: 1'b0, be: 4'b1111, wd: 32'h0};
      gq.push_back(g);
    end else if (ed) begin
      g = '{cycle: cyc, ignt: 1'b0, dgnt: 1'b1, addr: da, we: dw, be: be, wd: wd};
      gq.push_back(g);
    end
    if (!no_resp && (ei || (ed && !dw))) begin
      d = RD_BASE + cyc + 1;
      r = '{cycle: cyc + 1, iv: ei, dv: ed, idata: ei ? d : 32'h0, ddata: ed ? d : 32'h0};
      rq.push_back(r);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Both ports reading; ed/ei are the hand-derived winner for this cycle.
  task automatic both(input logic mr, input logic ei, input logic ed);
    step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 4'hF, 32'h0, mr, ei, ed, 1'b0);
  endtask

  initial begin
    Rst = 1'b0; IReq = 1'b1; IAddr = 32'h10; DReq = 1'b1; DAddr = 32'h20;
    DWrEn = 1'b0; DByteEn = 4'hF; DWrData = 32'h0; MemReady = 1'b1; MemRdData = 32'h1234_5678;
    #2;
    check("reset_grants", 128'({IGnt, DGnt, MemReq}), 128'(0));
    check("reset_resp", 128'({IRdValid, DRdValid, IRdData, DRdData}), 128'(0));
    IReq = 1'b0; DReq = 1'b0;
    @(posedge Clock); @(posedge Clock); #1;
    Rst = 1'b1;

    // single fetch
    step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();

    // starvation pattern: 4 data wins then a forced fetch, twice
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) both(1'b1, 1'b0, 1'b1);
      both(1'b1, 1'b1, 1'b0);
    end
    idle();

    // memory not ready holds the starve count
    both(1'b1, 1'b0, 1'b1);
    both(1'b1, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) both(1'b0, 1'b0, 1'b0);
    both(1'b1, 1'b0, 1'b1);
    both(1'b1, 1'b0, 1'b1);
    both(1'b1, 1'b1, 1'b0);
    idle();

    // store: no read response
    step(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 4'b0011, 32'hAABBCCDD, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();

    // dropping IReq clears the starve count
    for (int j = 0; j < 3; j++) both(1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h204, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) both(1'b1, 1'b0, 1'b1);
    both(1'b1, 1'b1, 1'b0);

    // alternating single-port reads
    step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 4'b0101, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h84, 1'b0, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();

    // reset mid-cycle after a data read grant kills its response
    step(1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    Rst = 1'b0;
    #1;
    check("rst_kills_resp", 128'({DRdValid, DRdData, IRdValid}), 128'(0));
    check("rst_forces_gnt", 128'({IGnt, DGnt, MemReq}), 128'(0));
    IReq = 1'b0; DReq = 1'b0;
    @(posedge Clock); #1;
    Rst = 1'b1;
    check("post_release_resp", 128'({DRdValid, IRdValid}), 128'(0));
    idle();
    idle();

    check("grant_queue_drained", 128'(gq.size()), 128'(0));
    check("resp_queue_drained", 128'(rq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
